// File: rtl/readout_sched_pkg.sv
// Shared types and default widths for the end-of-spill readout scheduler.
package readout_sched_pkg;

  localparam int unsigned CHAN_DEF = 8;
  localparam int unsigned NW_DEF   = 12;
  localparam int unsigned OFFW     = 16;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_DELAY = 3'd1,
    S_ARM   = 3'd2,
    S_HDR   = 3'd3,
    S_READ  = 3'd4,
    S_NEXT  = 3'd5,
    S_DONE  = 3'd6
  } state_t;

endpackage

// File: rtl/readout_sched_lsb_pick.sv
// Lowest-set-bit index of a vector plus a non-empty flag (purely combinational).
module lsb_pick #(
  parameter int unsigned N = 8,
  parameter int unsigned W = $clog2(N)
) (
  input  logic [N-1:0] vec,
  output logic [W-1:0] idx_c,
  output logic         any_c
);

  // Scan from the top so the lowest set bit is the last one to win.
  always_comb begin
    idx_c = '0;
    any_c = 1'b0;
    for (int i = int'(N) - 1; i >= 0; i--) begin
      if (vec[i]) begin
        idx_c = W'(i);
        any_c = 1'b1;
      end
    end
  end

endmodule

// File: rtl/readout_sched.sv
// Sequences one multi-channel ADC readout per end-of-spill: delay, arm, then
// header plus samples for each enabled channel, lowest index first.
module readout_sched
  import readout_sched_pkg::*;
#(
  parameter int unsigned CHAN = CHAN_DEF,
  parameter int unsigned SELW = $clog2(CHAN),
  parameter int unsigned NW   = NW_DEF
) (
  input  logic            CK50,
  input  logic            RST,
  input  logic            EOS,
  input  logic            ZYNQ_RD_EN,
  input  logic [CHAN-1:0] chan_mask,
  input  logic [OFFW-1:0] offset,
  input  logic [NW-1:0]   how_many,
  input  logic [CHAN-1:0] RODONE_n,
  output logic [CHAN-1:0] trigger,
  output logic [CHAN-1:0] rd_request,
  output logic [SELW-1:0] sel,
  output logic            hdr_valid,
  output logic            data_valid,
  output logic            busy,
  output logic            done,
  output logic            eos_missed
);

  state_t          state_q, state_d;
  logic [OFFW-1:0] cnt_q, cnt_d;
  logic [NW-1:0]   wcnt_q, wcnt_d, wcnt_inc;
  logic [NW-1:0]   hm_q, hm_d;
  logic [CHAN-1:0] pend_q, pend_d, rest;
  logic [CHAN-1:0] trig_d;
  logic [SELW-1:0] sel_d, arm_idx, next_idx;
  logic            arm_any, next_any;
  logic            eos_low_q, eos_low_d;
  logic            missed_d;

  // Channels still pending once the current one is retired.
  assign rest     = pend_q & ~(CHAN'(1) << sel_q_ext());
  assign wcnt_inc = wcnt_q + NW'(1);

  function automatic int unsigned sel_q_ext();
    return int'(sel);
  endfunction

  lsb_pick #(.N(CHAN), .W(SELW)) u_pick_arm (
    .vec   (pend_q),
    .idx_c (arm_idx),
    .any_c (arm_any)
  );

  lsb_pick #(.N(CHAN), .W(SELW)) u_pick_next (
    .vec   (rest),
    .idx_c (next_idx),
    .any_c (next_any)
  );

  // Next-state, datapath updates and the same-cycle sample pop.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    wcnt_d     = wcnt_q;
    hm_d       = hm_q;
    pend_d     = pend_q;
    trig_d     = trigger;
    sel_d      = sel;
    eos_low_d  = eos_low_q;
    missed_d   = eos_missed | (EOS && (state_q != S_IDLE) && (state_q != S_DONE));
    rd_request = '0;

    unique case (state_q)
      S_IDLE: begin
        // EOS must be seen low here before a new high level can start a readout.
        if (!EOS) begin
          eos_low_d = 1'b1;
        end else if (eos_low_q && (chan_mask != '0)) begin
          eos_low_d = 1'b0;
          pend_d    = chan_mask;
          hm_d      = how_many;
          cnt_d     = offset;
          state_d   = (offset == '0) ? S_ARM : S_DELAY;
        end
      end

      S_DELAY: begin
        cnt_d = cnt_q - OFFW'(1);
        if (cnt_q <= OFFW'(1)) begin
          state_d = S_ARM;
        end
      end

      S_ARM: begin
        trig_d  = pend_q;
        sel_d   = arm_idx;
        state_d = arm_any ? S_HDR : S_DONE;
      end

      S_HDR: begin
        if (ZYNQ_RD_EN) begin
          wcnt_d  = '0;
          state_d = (hm_q == '0) ? S_NEXT : S_READ;
        end
      end

      S_READ: begin
        rd_request[sel] = ZYNQ_RD_EN;
        if (ZYNQ_RD_EN) begin
          wcnt_d = wcnt_inc;
          if (wcnt_inc == hm_q) begin
            state_d = S_NEXT;
          end
        end
        if (!RODONE_n[sel]) begin
          state_d = S_NEXT;
        end
      end

      S_NEXT: begin
        pend_d[sel] = 1'b0;
        trig_d[sel] = 1'b0;
        sel_d       = next_idx;
        state_d     = next_any ? S_HDR : S_DONE;
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State, datapath and registered status outputs.
  always_ff @(posedge CK50) begin
    if (RST) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      wcnt_q     <= '0;
      hm_q       <= '0;
      pend_q     <= '0;
      eos_low_q  <= 1'b0;
      trigger    <= '0;
      sel        <= '0;
      hdr_valid  <= 1'b0;
      data_valid <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      eos_missed <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      wcnt_q     <= wcnt_d;
      hm_q       <= hm_d;
      pend_q     <= pend_d;
      eos_low_q  <= eos_low_d;
      trigger    <= trig_d;
      sel        <= sel_d;
      hdr_valid  <= (state_d == S_HDR);
      data_valid <= (state_d == S_READ);
      busy       <= (state_d != S_IDLE);
      done       <= (state_d == S_DONE);
      eos_missed <= missed_d;
    end
  end

endmodule

// File: tb/tb_readout_sched.sv
// Directed bench for readout_sched with a beat-level scoreboard and a simple channel buffer model.
module tb_readout_sched;

  localparam logic [1:0] K_HDR  = 2'd0;
  localparam logic [1:0] K_DATA = 2'd1;
  localparam logic [1:0] K_DONE = 2'd2;

  typedef struct packed {
    logic [1:0] kind;
    logic [2:0] ch;
  } beat_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        eos = 1'b0;
  logic        rd_en = 1'b0;
  logic [7:0]  chan_mask = 8'h00;
  logic [15:0] offset = 16'h0;
  logic [11:0] how_many = 12'h0;
  logic [7:0]  rodone_n;
  logic [7:0]  trigger, rd_request;
  logic [2:0]  sel;
  logic        hdr_valid, data_valid, busy, done, eos_missed;

  int    errors = 0;
  int    checks = 0;
  int    pop_cnt [8] = '{default: 0};
  int    base [8];
  int    depth_lim [8];
  beat_t exp_q [$];
  logic [7:0] cur_mask = 8'h00;
  logic  chk_en = 1'b0;
  logic  hold_q = 1'b0;

  readout_sched dut (
    .CK50       (clk),
    .RST        (rst),
    .EOS        (eos),
    .ZYNQ_RD_EN (rd_en),
    .chan_mask  (chan_mask),
    .offset     (offset),
    .how_many   (how_many),
    .RODONE_n   (rodone_n),
    .trigger    (trigger),
    .rd_request (rd_request),
    .sel        (sel),
    .hdr_valid  (hdr_valid),
    .data_valid (data_valid),
    .busy       (busy),
    .done       (done),
    .eos_missed (eos_missed)
  );

  always #10 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, required 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic beat_t mk(input logic [1:0] k, input int c);
    beat_t b;
    b.kind = k;
    b.ch   = 3'(c);
    return b;
  endfunction

  // Expected beat stream of one readout: channels ascending, header then min(how_many, buffer depth) pops.
  task automatic push_readout(input logic [7:0] mask, input int hm);
    int n;
    for (int c = 0; c < 8; c++) begin
      if (mask[c]) begin
        exp_q.push_back(mk(K_HDR, c));
        n = hm;
        if (depth_lim[c] != 0 && depth_lim[c] < n) n = depth_lim[c];
        for (int j = 0; j < n; j++) exp_q.push_back(mk(K_DATA, c));
      end
    end
    exp_q.push_back(mk(K_DONE, 0));
  endtask

  // Channel buffers: each pop drains one sample; RODONE_n drops while the last sample is presented.
  always @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < 8; i++) begin
        if (rd_request[i]) pop_cnt[i] <= pop_cnt[i] + 1;
      end
    end
  end

  always_comb begin
    rodone_n = 8'hFF;
    for (int i = 0; i < 8; i++) begin
      if (depth_lim[i] != 0 && (pop_cnt[i] - base[i]) >= depth_lim[i] - 1) rodone_n[i] = 1'b0;
    end
  end

  // Per-cycle comparison of the DUT against the expected beat stream.
  always @(negedge clk) begin
    beat_t      b;
    logic [1:0] k;
    if (chk_en && !rst) begin
      if (hold_q) chk("hdr_hold", 32'(hdr_valid), 32'd1);
      if (hdr_valid || data_valid || done) begin
        chk("valid_onehot", 32'($countones({hdr_valid, data_valid, done})), 32'd1);
        k = hdr_valid ? K_HDR : (data_valid ? K_DATA : K_DONE);
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_beat: got kind %0d sel %0d, required no beat at %0t", k, sel, $time);
        end else begin
          b = exp_q[0];
          chk("beat_kind", 32'(k), 32'(b.kind));
          if (b.kind == K_DONE) begin
            chk("trigger_done", 32'(trigger), 32'd0);
          end else begin
            chk("sel", 32'(sel), 32'(b.ch));
            chk("trigger", 32'(trigger), 32'(cur_mask & ~((8'd1 << b.ch) - 8'd1)));
          end
          if (data_valid) chk("rd_request", 32'(rd_request), 32'(rd_en ? (8'd1 << b.ch) : 8'd0));
          if (done || rd_en) void'(exp_q.pop_front());
        end
      end else begin
        chk("rd_request_idle", 32'(rd_request), 32'd0);
      end
      if (!busy) chk("trigger_idle", 32'(trigger), 32'd0);
      hold_q <= hdr_valid && !rd_en;
    end else begin
      hold_q <= 1'b0;
    end
  end

  task automatic snap();
    for (int i = 0; i < 8; i++) base[i] = pop_cnt[i];
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_trigger"}, 32'(trigger), 32'd0);
    chk({tag, "_rd_request"}, 32'(rd_request), 32'd0);
    chk({tag, "_sel"}, 32'(sel), 32'd0);
    chk({tag, "_hdr_valid"}, 32'(hdr_valid), 32'd0);
    chk({tag, "_data_valid"}, 32'(data_valid), 32'd0);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_done"}, 32'(done), 32'd0);
    chk({tag, "_eos_missed"}, 32'(eos_missed), 32'd0);
  endtask

  // EOS low for a cycle, then high for the start edge; the first header appears offset+1 edges later.
  task automatic start(input logic [7:0] mask, input logic [15:0] off, input int hm, input logic hold_eos);
    push_readout(mask, hm);
    cur_mask = mask;
    @(posedge clk); #1;
    eos = 1'b0;
    chan_mask = mask;
    offset = off;
    how_many = 12'(hm);
    @(posedge clk); #1;
    eos = 1'b1;
    @(posedge clk); #1;
    if (!hold_eos) eos = 1'b0;
    chan_mask = 8'hFF;
    offset = 16'd7;
    how_many = 12'hFFF;
    chk("busy_start", 32'(busy), 32'd1);
    if (off > 0) begin
      repeat (off) @(posedge clk);
      #1;
    end
    chk("hdr_not_yet", 32'(hdr_valid), 32'd0);
    @(posedge clk); #1;
    chk("hdr_first", 32'(hdr_valid), 32'd1);
    chk("trigger_arm", 32'(trigger), 32'(mask));
  endtask

  task automatic wait_done(input logic toggle, input int budget);
    int   n = 0;
    logic seen = 1'b0;
    while (!seen && n < budget) begin
      @(negedge clk);
      if (done) begin
        seen = 1'b1;
      end else begin
        @(posedge clk); #1;
        if (toggle) rd_en = ~rd_en;
        n++;
      end
    end
    chk("done_seen", 32'(seen), 32'd1);
    @(posedge clk); #1;
    chk("done_pulse", 32'(done), 32'd0);
    chk("busy_after", 32'(busy), 32'd0);
    chk("trigger_after", 32'(trigger), 32'd0);
    chk("queue_empty", 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    for (int i = 0; i < 8; i++) begin
      base[i] = 0;
      depth_lim[i] = 0;
    end
    repeat (3) @(posedge clk);
    #1;
    chk_all_zero("reset");
    rst = 1'b0;
    chk_en = 1'b1;

    // Two channels, offset 3, four samples each.
    rd_en = 1'b1;
    snap();
    start(8'h05, 16'd3, 4, 1'b0);
    wait_done(1'b0, 300);
    chk("t1_pops_ch0", pop_cnt[0] - base[0], 32'd4);
    chk("t1_pops_ch2", pop_cnt[2] - base[2], 32'd4);
    chk("t1_eos_missed", 32'(eos_missed), 32'd0);

    // Zero offset, zero samples: header only.
    snap();
    start(8'h80, 16'd0, 0, 1'b0);
    chk("t2_sel", 32'(sel), 32'd7);
    wait_done(1'b0, 100);
    chk("t2_pops_ch7", pop_cnt[7] - base[7], 32'd0);

    // Ready toggling every cycle, starting stalled on the first header.
    rd_en = 1'b0;
    snap();
    start(8'h06, 16'd2, 5, 1'b0);
    wait_done(1'b1, 400);
    chk("t3_pops_ch1", pop_cnt[1] - base[1], 32'd5);
    chk("t3_pops_ch2", pop_cnt[2] - base[2], 32'd5);

    // Channel 1 buffer runs dry after two samples.
    rd_en = 1'b1;
    depth_lim[1] = 2;
    snap();
    start(8'h02, 16'd1, 10, 1'b0);
    wait_done(1'b0, 200);
    chk("t4_pops_ch1", pop_cnt[1] - base[1], 32'd2);
    depth_lim[1] = 0;

    // EOS held high: one readout only, flagged as missed; re-arms after EOS low.
    snap();
    start(8'h01, 16'd2, 3, 1'b1);
    wait_done(1'b0, 200);
    chk("t5_eos_missed", 32'(eos_missed), 32'd1);
    repeat (6) @(posedge clk);
    #1;
    chk("t5_no_rearm", 32'(busy), 32'd0);
    start(8'h01, 16'd0, 2, 1'b0);
    wait_done(1'b0, 200);
    chk("t5_pops_ch0", pop_cnt[0] - base[0], 32'd5);
    chk("t5_missed_sticky", 32'(eos_missed), 32'd1);

    // Reset in the middle of a channel read.
    snap();
    start(8'h03, 16'd1, 8, 1'b0);
    begin
      int n = 0;
      while (!data_valid && n < 50) begin
        @(posedge clk); #1;
        n++;
      end
      chk("t6_reach_read", 32'(data_valid), 32'd1);
    end
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    exp_q.delete();
    chk_all_zero("t6_rst");
    rst = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    chk("t6_idle_busy", 32'(busy), 32'd0);
    snap();
    start(8'h01, 16'd1, 2, 1'b0);
    wait_done(1'b0, 200);
    chk("t6_pops_ch0", pop_cnt[0] - base[0], 32'd2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #400000;
    errors++;
    checks++;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
